// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one external combinational ALU between two requesters. A grant
//   steers the winner's opcode/operands onto the ALU and captures the ALU
//   result on the same edge. The captured result is held as a one-entry
//   response for the winner until that requester consumes it. A new grant
//   can happen in the same cycle the held response is consumed.
//
//   State table
//     state | meaning
//     IDLE  | no response held; any valid requester may be granted
//     HOLD  | one response held for requester `owner`; re-grant only when
//           | the owner consumes it this cycle
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   req_valid_i[k]   requester k has an operation pending
//   req_ready_o[k]   requester k is accepted this cycle (at most one bit)
//   req_op_i[k]      5-bit opcode from requester k
//   req_a_i[k]       operand a from requester k
//   req_b_i[k]       operand b from requester k
//   alu_op_o         opcode to the shared ALU (zero when nothing is granted)
//   alu_a_o          operand a to the shared ALU
//   alu_b_o          operand b to the shared ALU
//   alu_result_i     ALU result, combinational from alu_*_o
//   rsp_valid_o[k]   a response is held for requester k (one-hot or zero)
//   rsp_ready_i[k]   requester k consumes its response
//   rsp_data_o       held result (zero for an illegal opcode)
//   rsp_err_o        held operation used an illegal opcode
module alu_share_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid_i,
  output logic [1:0]  req_ready_o,
  input  logic [4:0]  req_op_i [2],
  input  logic [31:0] req_a_i  [2],
  input  logic [31:0] req_b_i  [2],
  output logic [4:0]  alu_op_o,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  input  logic [31:0] alu_result_i,
  output logic [1:0]  rsp_valid_o,
  input  logic [1:0]  rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o
);

  localparam logic [4:0] OP_LAST_LEGAL = 5'h09;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic        owner, owner_nxt;
  logic        prio, prio_nxt;
  logic [31:0] data, data_nxt;
  logic        err, err_nxt;

  logic        any_valid;
  logic        sel;
  logic        can_grant;
  logic        grant;
  logic        op_legal;

  // Requester selection: the priority pointer only matters under contention.
  always_comb begin
    any_valid = |req_valid_i;
    if (&req_valid_i) begin
      sel = prio;
    end else begin
      sel = req_valid_i[1];
    end
  end

  // In HOLD the owner's rsp_valid_o is high by construction, so the
  // back-to-back condition reduces to the owner's rsp_ready_i. The
  // non-owner's rsp_ready_i never enters this term.
  always_comb begin
    can_grant = (state == IDLE) || rsp_ready_i[owner];
    // rst_n gates the grant so req_ready_o is forced low during reset.
    grant     = rst_n && any_valid && can_grant;
    op_legal  = (alu_op_o <= OP_LAST_LEGAL);
  end

  always_comb begin
    req_ready_o = 2'b00;
    alu_op_o    = '0;
    alu_a_o     = '0;
    alu_b_o     = '0;
    if (grant) begin
      req_ready_o[sel] = 1'b1;
      alu_op_o         = req_op_i[sel];
      alu_a_o          = req_a_i[sel];
      alu_b_o          = req_b_i[sel];
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    prio_nxt  = prio;
    data_nxt  = data;
    err_nxt   = err;
    case (state)
      IDLE: begin
        if (grant) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (!grant && rsp_ready_i[owner]) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (grant) begin
      owner_nxt = sel;
      prio_nxt  = ~sel;
      err_nxt   = ~op_legal;
      data_nxt  = op_legal ? alu_result_i : 32'h0000_0000;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= 1'b0;
      prio  <= 1'b0;
      data  <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      prio  <= prio_nxt;
      data  <= data_nxt;
      err   <= err_nxt;
    end
  end

  // State is cleared asynchronously, so a held response vanishes the moment
  // reset asserts and is never re-presented.
  always_comb begin
    rsp_valid_o = 2'b00;
    if (state == HOLD) begin
      rsp_valid_o[owner] = 1'b1;
    end
    rsp_data_o = data;
    rsp_err_o  = err;
  end

endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports req_valid_i[k]  input  1  requester k (k=0,1) has an operation pending.
REQ-004 SHALL have ports req_ready_o[k]  output  1  arbiter accepts requester k this cycle.
REQ-005 SHALL have ports req_op_i[k]  input  5  ALU opcode from requester k.
REQ-006 SHALL have ports req_a_i[k], req_b_i[k]  input  32 each  operands from requester k.
REQ-007 SHALL have ports alu_op_o  output  5, alu_a_o  output  32, alu_b_o  output  32  drive the shared combinational ALU.
REQ-008 SHALL have port alu_result_i  input  32  shared ALU result, same cycle as its inputs.
REQ-009 SHALL have ports rsp_valid_o[k]  output  1  result held for requester k.
REQ-010 SHALL have ports rsp_ready_i[k]  input  1  requester k consumes its response.
REQ-011 SHALL have port rsp_data_o  output  32  held result, shared by both requesters.
REQ-012 SHALL have port rsp_err_o  output  1  held operation used an illegal opcode.

Function
REQ-013 SHALL implement a two-state FSM: IDLE (no response held) and HOLD (one response held for owner k).
REQ-014 SHALL hold a one-bit priority pointer; the pointed-to requester wins when both are valid.
REQ-015 SHALL assert at most one req_ready_o per cycle, and only for a valid requester.
REQ-016 SHALL grant when in IDLE, or in HOLD while rsp_valid_o[owner] and rsp_ready_i[owner] are both high (back-to-back).
REQ-017 SHALL drive alu_op_o/alu_a_o/alu_b_o combinationally from the selected requester; when no requester is selected, drive all zero.
REQ-018 SHALL, on a grant edge, register alu_result_i into rsp_data_o, record the owner, set rsp_err_o, and enter HOLD. rsp_valid_o[owner] SHALL be high the next cycle (latency 1).
REQ-019 SHALL treat opcodes 0x00-0x09 as legal. For opcodes 0x0A-0x1F, rsp_err_o SHALL be 1 and rsp_data_o SHALL be 0x00000000.
REQ-020 SHALL, after each grant to requester k, set the priority pointer to 1-k. With no grant, the pointer SHALL be unchanged.
REQ-021 SHALL stay in HOLD with rsp_data_o, rsp_err_o and the owner stable while rsp_ready_i[owner] is low.
REQ-022 SHALL ignore rsp_ready_i of the non-owner.
REQ-023 SHALL return to IDLE when the response is consumed and no new grant occurs in that same cycle.
REQ-024 SHALL never assert rsp_valid_o[0] and rsp_valid_o[1] together.
REQ-025 SHALL use wrap-around 32-bit arithmetic in the external ALU; the arbiter SHALL pass operands unmodified.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously force:
- state IDLE and priority pointer 0
- rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0, req_ready_o=0
REQ-027 SHALL, if reset asserts during HOLD, discard the held response and not re-present it after reset.
REQ-028 SHALL grant no request before the first rising clk edge after rst_n deasserts.

Verification
REQ-029 Single request, no contention: r0 op=0x00, a=5, b=7, rsp_ready held 1.
- Expected: req_ready_o[0]=1 in cycle 0.
- Expected: cycle 1 has rsp_valid_o[0]=1, rsp_data_o=12, rsp_err_o=0.
REQ-030 Contention after reset: both valid continuously; r0 op=0x01 a=10 b=3; r1 op=0x04 a=0xF0 b=0x0F; both rsp_ready held 1.
- Expected: grants alternate r0, r1, r0.
- Expected: responses are 7, 0xFF, 7 on consecutive cycles.
REQ-031 Backpressure: r1 grant with op=0x09, a=0x80000000, b=4; rsp_ready_i[1]=0 for 3 cycles.
- Expected: rsp_data_o=0xF8000000, stable for 3 cycles.
- Expected: no req_ready_o while stalled, including while r0 is valid.
- Expected: r0 is granted on the cycle rsp_ready_i[1]=1.
REQ-032 Illegal opcode: r0 op=0x1F.
- Expected: next cycle rsp_valid_o[0]=1, rsp_err_o=1, rsp_data_o=0.
REQ-033 Reset mid-HOLD: pull rst_n low while rsp_valid_o[1]=1.
- Expected: rsp_valid_o[1]=0 immediately, without waiting for a clock edge.
- Expected: after release with both requesters valid, r0 is granted first.
REQ-034 Signed compare: op=0x02, a=0xFFFFFFFF, b=1 -> rsp_data_o=1. Unsigned compare: op=0x03, same operands -> rsp_data_o=0.
